// File: rtl/csr_file_v2.sv
// Machine-mode CSR file: mstatus/mie/mtvec/mepc/mcause/mip, 64-bit cycle and
// retire counters, level interrupt arbitration and combinational read port.
module csr_file_v2 #(
    parameter int          NUM_IRQ   = 2,
    parameter logic [31:0] MTVEC_RST = 32'h0001_0000,
    parameter bit          CNT_EN    = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               csr_we,
    input  logic [11:0]        wb_csr_addr,
    input  logic [31:0]        wb_csr_data,
    input  logic [11:0]        rd_csr_addr,
    output logic [31:0]        rd_csr_data,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               trap_take,
    input  logic [31:0]        trap_pc,
    input  logic               mret,
    input  logic               inst_retire,
    output logic               irq_req,
    output logic [3:0]         irq_id,
    output logic [31:0]        mtvec_pc,
    output logic [31:0]        mepc_pc
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;
    localparam logic [31:0] IRQ_MASK    = 32'({{NUM_IRQ{1'b1}}, 16'd0});

    logic               mst_mie_q, mst_mie_d;
    logic               mst_mpie_q, mst_mpie_d;
    logic [NUM_IRQ-1:0] mie_en_q, mie_en_d;
    logic [NUM_IRQ-1:0] mip_q;
    logic [31:0]        mtvec_q, mtvec_d;
    logic [31:0]        mepc_q, mepc_d;
    logic [31:0]        mcause_q, mcause_d;
    logic [63:0]        mcycle_q, mcycle_d;
    logic [63:0]        minstret_q, minstret_d;

    logic [NUM_IRQ-1:0] pend_s;
    logic [3:0]         irq_id_s;
    logic [31:0]        wr_val_s;
    logic               wr_ok_s;
    logic               wr_hit_s;
    logic [31:0]        rd_val_s;

    // MPP is hardwired to machine mode; only MIE and MPIE are stored.
    function automatic logic [31:0] mstatus_val(input logic mie_b, input logic mpie_b);
        return {19'd0, 2'b11, 3'd0, mpie_b, 3'd0, mie_b, 3'd0};
    endfunction

    // Enabled-pending arbitration: lowest source index wins.
    always_comb begin
        pend_s   = mip_q & mie_en_q;
        irq_id_s = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            irq_id_s = pend_s[i] ? 4'(i) : irq_id_s;
        end
    end

    assign irq_req  = mst_mie_q & (|pend_s);
    assign irq_id   = irq_id_s;
    assign mtvec_pc = mtvec_q;
    assign mepc_pc  = mepc_q;

    // Write decode: legalised value and whether the address is writable.
    always_comb begin
        wr_val_s = 32'd0;
        wr_ok_s  = 1'b0;
        case (wb_csr_addr)
            A_MSTATUS: begin
                wr_val_s = mstatus_val(wb_csr_data[3], wb_csr_data[7]);
                wr_ok_s  = 1'b1;
            end
            A_MIE: begin
                wr_val_s = wb_csr_data & IRQ_MASK;
                wr_ok_s  = 1'b1;
            end
            A_MTVEC, A_MEPC: begin
                wr_val_s = wb_csr_data & 32'hFFFF_FFFC;
                wr_ok_s  = 1'b1;
            end
            A_MCAUSE: begin
                wr_val_s = wb_csr_data;
                wr_ok_s  = 1'b1;
            end
            A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH: begin
                wr_val_s = CNT_EN ? wb_csr_data : 32'd0;
                wr_ok_s  = CNT_EN;
            end
            default: begin
                wr_val_s = 32'd0;
                wr_ok_s  = 1'b0;
            end
        endcase
        wr_hit_s = csr_we & wr_ok_s;
    end

    // Read mux with same-cycle write bypass for writable CSRs.
    always_comb begin
        rd_val_s = 32'd0;
        case (rd_csr_addr)
            A_MSTATUS:               rd_val_s = mstatus_val(mst_mie_q, mst_mpie_q);
            A_MIE:                   rd_val_s = 32'({mie_en_q, 16'd0});
            A_MTVEC:                 rd_val_s = mtvec_q;
            A_MEPC:                  rd_val_s = mepc_q;
            A_MCAUSE:                rd_val_s = mcause_q;
            A_MIP:                   rd_val_s = 32'({mip_q, 16'd0});
            A_MCYCLE, A_CYCLE:       rd_val_s = CNT_EN ? mcycle_q[31:0] : 32'd0;
            A_MCYCLEH, A_CYCLEH:     rd_val_s = CNT_EN ? mcycle_q[63:32] : 32'd0;
            A_MINSTRET, A_INSTRET:   rd_val_s = CNT_EN ? minstret_q[31:0] : 32'd0;
            A_MINSTRETH, A_INSTRETH: rd_val_s = CNT_EN ? minstret_q[63:32] : 32'd0;
            default:                 rd_val_s = 32'd0;
        endcase
        if (wr_hit_s && (rd_csr_addr == wb_csr_addr)) begin
            rd_csr_data = wr_val_s;
        end else begin
            rd_csr_data = rd_val_s;
        end
    end

    // Next-state: software write beats trap entry, which beats mret, per CSR.
    always_comb begin
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        if (wr_hit_s && (wb_csr_addr == A_MSTATUS)) begin
            mst_mie_d  = wb_csr_data[3];
            mst_mpie_d = wb_csr_data[7];
        end else if (trap_take) begin
            mst_mie_d  = 1'b0;
            mst_mpie_d = mst_mie_q;
        end else if (mret) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
        end else begin
            mst_mie_d  = mst_mie_q;
            mst_mpie_d = mst_mpie_q;
        end

        if (wr_hit_s && (wb_csr_addr == A_MIE)) begin
            mie_en_d = wb_csr_data[16 +: NUM_IRQ];
        end else begin
            mie_en_d = mie_en_q;
        end

        if (wr_hit_s && (wb_csr_addr == A_MTVEC)) begin
            mtvec_d = wr_val_s;
        end else begin
            mtvec_d = mtvec_q;
        end

        if (wr_hit_s && (wb_csr_addr == A_MEPC)) begin
            mepc_d = wr_val_s;
        end else if (trap_take) begin
            mepc_d = trap_pc & 32'hFFFF_FFFC;
        end else begin
            mepc_d = mepc_q;
        end

        if (wr_hit_s && (wb_csr_addr == A_MCAUSE)) begin
            mcause_d = wr_val_s;
        end else if (trap_take) begin
            mcause_d = {1'b1, 26'd0, 5'd16 + {1'b0, irq_id_s}};
        end else begin
            mcause_d = mcause_q;
        end

        // A 64-bit add keeps the high-half carry in the same cycle as the low wrap.
        if (!CNT_EN) begin
            mcycle_d = 64'd0;
        end else if (wr_hit_s && (wb_csr_addr == A_MCYCLE)) begin
            mcycle_d = {mcycle_q[63:32], wb_csr_data};
        end else if (wr_hit_s && (wb_csr_addr == A_MCYCLEH)) begin
            mcycle_d = {wb_csr_data, mcycle_q[31:0]};
        end else begin
            mcycle_d = mcycle_q + 64'd1;
        end

        if (!CNT_EN) begin
            minstret_d = 64'd0;
        end else if (wr_hit_s && (wb_csr_addr == A_MINSTRET)) begin
            minstret_d = {minstret_q[63:32], wb_csr_data};
        end else if (wr_hit_s && (wb_csr_addr == A_MINSTRETH)) begin
            minstret_d = {wb_csr_data, minstret_q[31:0]};
        end else if (inst_retire) begin
            minstret_d = minstret_q + 64'd1;
        end else begin
            minstret_d = minstret_q;
        end
    end

    // State registers; reset overrides any same-cycle trap or write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mie_en_q   <= '0;
            mip_q      <= '0;
            mtvec_q    <= MTVEC_RST;
            mepc_q     <= 32'd0;
            mcause_q   <= 32'd0;
            mcycle_q   <= 64'd0;
            minstret_q <= 64'd0;
        end else begin
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mie_en_q   <= mie_en_d;
            mip_q      <= irq_in;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

endmodule
